spi_byte_master: RTL and testbench
==================================

# spi_byte_master

Byte-level SPI master (mode 0: CPOL=0, CPHA=0) that sits directly downstream of the SPI mode/command sequencer. It accepts one command/data byte per `start` pulse, shifts it out on MOSI while shifting in MISO, then returns the received byte on `slave_output` together with a `done` pulse. Chip select is owned by the sequencer, not by this block; `busy` is the back-pressure signal the sequencer waits on.

## Interface
- `CLK_DIV`, default 2: SCLK half-period in `clk` cycles; legal range 1..255.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  transfer request; sampled only while idle.
- `byte_in`  in  8  byte to transmit; captured on the accepting edge.
- `miso`  in  1  serial data from slave.
- `busy`  out  1  high from acceptance through the `done` cycle.
- `done`  out  1  one-cycle pulse when `slave_output` is updated.
- `slave_output`  out  8  last received byte; held until the next `done`.
- `sclk`  out  1  SPI clock, idles low.
- `mosi`  out  1  serial data to slave.

## Operation
- Reset: `busy`=0, `done`=0, `slave_output`=8'h00, `sclk`=0, `mosi`=0, state IDLE, all counters 0. Reset mid-transfer aborts immediately with the same values; no partial byte is reported.
- States: IDLE, LEAD, HIGH, LOW, DONE.
- IDLE: `start`=1 -> load shift register with `byte_in`, bit counter=7, `mosi`=`byte_in[7]`, `busy`=1, enter LEAD.
- LEAD: `sclk`=0 for `CLK_DIV` cycles, then -> HIGH.
- HIGH: `sclk`=1 for `CLK_DIV` cycles. On the edge that leaves HIGH, sample `miso` into the receive shift register (LSB side, shifting left). If bit counter = 0 -> DONE; else -> LOW.
- LOW: on entry `sclk`=0, decrement bit counter and drive next transmit bit on `mosi`; hold `CLK_DIV` cycles, then -> HIGH.
- DONE: `sclk`=0, `slave_output` <= received byte, `done`=1 for this single cycle, `busy` still 1; next cycle -> IDLE with `busy`=0, `mosi` holds last bit.
- `start` while not IDLE (including the DONE cycle) is ignored; nothing is queued.
- `byte_in` changes after acceptance have no effect on the transfer in progress.
- Divider counter width is 8 bits; it reloads on every phase change and never wraps mid-phase.

## Timing
- Acceptance edge E0 -> `busy` high and `mosi` valid from the cycle after E0.
- `busy` stays high for exactly 16·`CLK_DIV`+1 cycles (33 at the default); `done` is in the last of these.
- First SCLK rising edge occurs `CLK_DIV` cycles after `busy` rises. MOSI changes only while `sclk`=0, at least `CLK_DIV` cycles before each rising SCLK.
- MISO is sampled on the `clk` edge that drops SCLK. The slave must hold data valid through that edge.
- Back-to-back: `start` held high across `done` re-accepts on the first IDLE cycle. The minimum gap between transfers is one idle cycle with `busy`=0.

## Configuration
- `SPI_LSB_FIRST_EN` defined: transmit `byte_in[0]` first and assemble the received byte LSB-first (first sampled bit -> `slave_output[0]`).
- Undefined (default): MSB-first in both directions, as described above. Cycle timing is identical in both builds.

## Structure
- Shared package `spi_pkg`: state encoding constants (IDLE, LEAD, HIGH, LOW, DONE), `SPI_BYTE_W`=8, and the default `CLK_DIV`. The sequencer and this block both include it.
- One sub-module, `spi_clk_div`: loadable down-counter producing a one-cycle `phase_end` tick after `CLK_DIV` cycles, restarted by the FSM on every phase change.

## Test plan
- Reset mid-transfer: assert `rst` low during bit 3 -> all outputs return to reset values immediately; the next `start` produces a full 33-cycle transfer.
- Basic byte, `CLK_DIV`=2: `byte_in`=8'hBF, slave model returns 8'h1F -> MOSI bit stream 1,0,1,1,1,1,1,1; 8 SCLK pulses of 2 high/2 low; `slave_output`=8'h1F with `done` in the 33rd busy cycle.
- Busy-ignore: pulse `start` with 8'h34 in the 10th busy cycle and again in the DONE cycle -> both ignored; exactly one `done`; `slave_output` equals the first transfer's response.
- Back-to-back: hold `start` high with 8'h05 then 8'h06 -> second transfer begins after exactly one `busy`=0 cycle; two `done` pulses; responses 8'hA5 and 8'h5A are captured in order.
- `CLK_DIV`=1 corner: `byte_in`=8'h00, MISO tied high -> `busy` lasts 17 cycles, `slave_output`=8'hFF, SCLK toggles every cycle.
- `SPI_LSB_FIRST_EN` build: `byte_in`=8'h01, slave returns bit stream 1,0,0,0,0,0,0,0 -> first MOSI bit 1, remaining bits 0; `slave_output`=8'h01.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: state encoding, byte width, default divider and bit-order helpers.
// Defining SPI_LSB_FIRST_EN switches both shift directions to LSB-first.
package spi_pkg;

  localparam int SPI_BYTE_W      = 8;
  localparam int SPI_CLK_DIV_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEAD = 3'd1,
    ST_HIGH = 3'd2,
    ST_LOW  = 3'd3,
    ST_DONE = 3'd4
  } spi_state_e;

  // Bit placed on MOSI from a transmit shift register.
  function automatic logic first_bit(input logic [SPI_BYTE_W-1:0] b);
`ifdef SPI_LSB_FIRST_EN
    return b[0];
`else
    return b[SPI_BYTE_W-1];
`endif
  endfunction

  function automatic logic [SPI_BYTE_W-1:0] tx_shift(input logic [SPI_BYTE_W-1:0] b);
`ifdef SPI_LSB_FIRST_EN
    return b >> 1;
`else
    return b << 1;
`endif
  endfunction

  // Receive assembly: first sampled bit ends at the MSB (default) or LSB.
  function automatic logic [SPI_BYTE_W-1:0] rx_shift(input logic [SPI_BYTE_W-1:0] rx,
                                                     input logic              b);
`ifdef SPI_LSB_FIRST_EN
    return {b, rx[SPI_BYTE_W-1:1]};
`else
    return {rx[SPI_BYTE_W-2:0], b};
`endif
  endfunction

endpackage

// File: rtl/spi_byte_master_if.sv
// Command/data handshake plus SPI pins of the byte master.
// 'slave' is the byte master's view; 'master' is the sequencer and SPI bus side.
interface spi_byte_master_if;
  import spi_pkg::*;

  logic                  start;
  logic [SPI_BYTE_W-1:0] byte_in;
  logic                  miso;
  logic                  busy;
  logic                  done;
  logic [SPI_BYTE_W-1:0] slave_output;
  logic                  sclk;
  logic                  mosi;

  modport master (
    output start, byte_in, miso,
    input  busy, done, slave_output, sclk, mosi
  );

  modport slave (
    input  start, byte_in, miso,
    output busy, done, slave_output, sclk, mosi
  );

endinterface

// File: rtl/spi_clk_div.sv
// Loadable phase timer: after a load, phase_end ticks in the CLK_DIV-th cycle of the phase.
// The FSM reloads it on every phase change, so it never wraps mid-phase.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic load,
  output logic phase_end
);

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  // NOTE: clocked state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 8'd0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign phase_end = run && (cnt == 8'd0);

endmodule

// File: rtl/spi_byte_master.sv
// Mode-0 SPI byte master: shifts byte_in out on MOSI while assembling MISO into slave_output.
// Bit order follows SPI_LSB_FIRST_EN (undefined: MSB-first); timing is the same in both builds.
module spi_byte_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV_DEF  // SCLK half-period in clk cycles, 1..255
) (
  input  logic              clk,
  input  logic              rst,
  spi_byte_master_if.slave  bus
);

  spi_state_e            state;
  logic [SPI_BYTE_W-1:0] tx_sh;
  logic [SPI_BYTE_W-1:0] rx_sh;
  logic [2:0]            bit_cnt;
  logic                  busy_q;
  logic                  done_q;
  logic [SPI_BYTE_W-1:0] out_q;
  logic                  sclk_q;
  logic                  mosi_q;
  logic                  phase_end;
  logic                  load;

  // Restart the phase timer on acceptance and at every phase boundary.
  assign load = (state == ST_IDLE) ? bus.start : phase_end;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk       (clk),
    .rst       (rst),
    .run       (busy_q),
    .load      (load),
    .phase_end (phase_end)
  );

  // NOTE: every register, shift registers included, is reset so an aborted transfer leaves nothing behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      tx_sh   <= '0;
      rx_sh   <= '0;
      bit_cnt <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            tx_sh   <= bus.byte_in;
            rx_sh   <= '0;
            bit_cnt <= 3'd7;
            mosi_q  <= first_bit(bus.byte_in);
            busy_q  <= 1'b1;
            state   <= ST_LEAD;
          end
        end
        ST_LEAD: begin
          if (phase_end) begin
            sclk_q <= 1'b1;
            state  <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          // Falling SCLK edge: the slave's bit is still valid here.
          if (phase_end) begin
            sclk_q <= 1'b0;
            rx_sh  <= rx_shift(rx_sh, bus.miso);
            if (bit_cnt == 3'd0) begin
              out_q  <= rx_shift(rx_sh, bus.miso);
              done_q <= 1'b1;
              state  <= ST_DONE;
            end else begin
              bit_cnt <= bit_cnt - 3'd1;
              tx_sh   <= tx_shift(tx_sh);
              mosi_q  <= first_bit(tx_shift(tx_sh));
              state   <= ST_LOW;
            end
          end
        end
        ST_LOW: begin
          if (phase_end) begin
            sclk_q <= 1'b1;
            state  <= ST_HIGH;
          end
        end
        ST_DONE: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.slave_output = out_q;
  assign bus.sclk         = sclk_q;
  assign bus.mosi         = mosi_q;

endmodule

// File: tb/tb_spi_byte_master.sv
// Self-checking bench for spi_byte_master: cycle-level behavioural model, SPI slave model,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_spi_byte_master;

  localparam int CD   = 2;
  localparam int XFER = 16 * CD + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_byte_master_if bus ();
  spi_byte_master_if bus1 ();

  spi_byte_master #(.CLK_DIV(CD)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  spi_byte_master #(.CLK_DIV(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Bit sent in position j (0 = first on the wire).
  function automatic logic tx_bit(input logic [7:0] b, input int j);
`ifdef SPI_LSB_FIRST_EN
    return b[3'(j)];
`else
    return b[3'(7 - j)];
`endif
  endfunction

  // ---------------- behavioural model: k = cycles since acceptance ----------------
  int         m_k    = 0;
  logic [7:0] m_tx   = 8'h00;
  logic [7:0] m_resp = 8'h00;
  logic [7:0] m_out  = 8'h00;
  logic       m_mosi = 1'b0;
  logic [7:0] resp_next = 8'h00;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_k    <= 0;
      m_out  <= 8'h00;
      m_mosi <= 1'b0;
    end else if (m_k == 0) begin
      if (bus.start) begin
        m_k    <= 1;
        m_tx   <= bus.byte_in;
        m_resp <= resp_next;
      end
    end else if (m_k == XFER) begin
      m_k    <= 0;
      m_out  <= m_resp;
      m_mosi <= tx_bit(m_tx, 7);
    end else begin
      m_k <= m_k + 1;
    end
  end

  // {busy, done, sclk, mosi, slave_output}; phases of CD cycles: LEAD, then HIGH/LOW alternating.
  function automatic logic [11:0] model_vec();
    int p;
    if (m_k == 0)    return {1'b0, 1'b0, 1'b0, m_mosi, m_out};
    if (m_k == XFER) return {1'b1, 1'b1, 1'b0, tx_bit(m_tx, 7), m_resp};
    p = (m_k - 1) / CD;
    return {1'b1, 1'b0, 1'((p % 2) == 1), tx_bit(m_tx, p / 2), m_out};
  endfunction

  always @(negedge clk)
    check("cycle", {20'd0, bus.busy, bus.done, bus.sclk, bus.mosi, bus.slave_output},
          {20'd0, model_vec()});

  // ---------------- SPI slave: next bit after every falling SCLK ----------------
  int   s_idx    = 0;
  logic s_sclk_q = 1'b0;

  always @(negedge clk) begin
    if (!bus.busy) s_idx <= 0;
    else if (s_sclk_q && !bus.sclk) s_idx <= s_idx + 1;
    s_sclk_q <= bus.sclk;
  end

  assign bus.miso  = (s_idx < 8) ? tx_bit(m_resp, s_idx) : 1'b0;
  assign bus1.miso = 1'b1;

  // ---------------- monitor: wire-order MOSI bits, busy length, done log ----------------
  logic       mon_busy_q = 1'b0;
  logic       mon_sclk_q = 1'b0;
  int         mon_len    = 0;
  int         done_len   = 0;
  int         done_cnt   = 0;
  logic [7:0] mon_bits   = 8'h00;
  logic [7:0] done_q[$];

  always @(negedge clk) begin
    mon_busy_q <= bus.busy;
    mon_sclk_q <= bus.sclk;
    if (bus.busy && !mon_busy_q) mon_len <= 1;
    else if (bus.busy) mon_len <= mon_len + 1;
    if (bus.sclk && !mon_sclk_q) mon_bits <= {mon_bits[6:0], bus.mosi};
    if (bus.done) begin
      done_cnt <= done_cnt + 1;
      done_len <= mon_len + 1;
      done_q.push_back(bus.slave_output);
    end
  end

  task automatic wait_done(input string name);
    int t = 0;
    while (bus.done !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check({name, " done seen"}, {31'd0, bus.done}, 32'd1);
  endtask

  task automatic xfer(input logic [7:0] b, input logic [7:0] r, input string name);
    @(negedge clk);
    bus.start = 1'b1; bus.byte_in = b; resp_next = r;
    @(negedge clk);
    bus.start = 1'b0; bus.byte_in = ~b;
    wait_done(name);
    #1;
  endtask

  int         base;
  int         d1_len;
  logic [15:0] d1_pat;
  logic       d1_mosi;
  logic [7:0] d1_out;

  initial begin
    bus.start  = 1'b0; bus.byte_in  = 8'h00;
    bus1.start = 1'b0; bus1.byte_in = 8'h00;
    repeat (3) @(negedge clk);
    check("reset outputs", {20'd0, bus.busy, bus.done, bus.sclk, bus.mosi, bus.slave_output}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Basic byte: BF out, 1F back.
    xfer(8'hBF, 8'h1F, "basic");
`ifdef SPI_LSB_FIRST_EN
    check("basic mosi stream", {24'd0, mon_bits}, 32'hFD);
`else
    check("basic mosi stream", {24'd0, mon_bits}, 32'hBF);
`endif
    check("basic slave_output", {24'd0, bus.slave_output}, 32'h1F);
    check("basic busy length", done_len, 33);

    // Starts in busy cycle 10 and in the DONE cycle are ignored.
    base = done_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.byte_in = 8'hA7; resp_next = 8'h3C;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.start = 1'b1; bus.byte_in = 8'h34; resp_next = 8'hEE;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("ignore");
    bus.start = 1'b1; bus.byte_in = 8'h34;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("ignore done count", done_cnt - base, 1);
    check("ignore slave_output", {24'd0, bus.slave_output}, 32'h3C);
    check("ignore busy low", {31'd0, bus.busy}, 32'd0);

    // Back-to-back with start held: exactly one idle cycle between transfers.
    base = done_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.byte_in = 8'h05; resp_next = 8'hA5;
    @(negedge clk);
    bus.byte_in = 8'h06; resp_next = 8'h5A;
    check("b2b first busy", {31'd0, bus.busy}, 32'd1);
    wait_done("b2b first");
    @(negedge clk);
    check("b2b gap busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    check("b2b second busy", {31'd0, bus.busy}, 32'd1);
    bus.start = 1'b0;
    wait_done("b2b second");
    #1;
    check("b2b done count", done_cnt - base, 2);
    check("b2b first response", {24'd0, done_q[done_q.size() - 2]}, 32'hA5);
    check("b2b second response", {24'd0, done_q[done_q.size() - 1]}, 32'h5A);

    // Reset during bit 3, then a clean full transfer.
    @(negedge clk);
    bus.start = 1'b1; bus.byte_in = 8'h96; resp_next = 8'h69;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst = 1'b0;
    #1 check("mid reset outputs", {20'd0, bus.busy, bus.done, bus.sclk, bus.mosi, bus.slave_output}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    xfer(8'h3C, 8'hC3, "post reset");
    check("post reset busy length", done_len, 33);
    check("post reset slave_output", {24'd0, bus.slave_output}, 32'hC3);

`ifdef SPI_LSB_FIRST_EN
    xfer(8'h01, 8'h01, "lsb");
    check("lsb mosi stream", {24'd0, mon_bits}, 32'h80);
    check("lsb slave_output", {24'd0, bus.slave_output}, 32'h01);
`endif

    // Randomized traffic, including starts while busy and one asynchronous reset.
    base = done_cnt;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (i == 702) rst = 1'b1;
      bus.start   = ($urandom_range(0, 2) == 0);
      bus.byte_in = 8'($urandom);
      resp_next   = 8'($urandom);
      if (i == 700) #3 rst = 1'b0;
    end
    bus.start = 1'b0;
    repeat (XFER + 5) @(negedge clk);
    #1;
    check("random transfers completed", {31'd0, (done_cnt - base) > 20}, 32'd1);

    // CLK_DIV=1 corner on the second instance, MISO tied high.
    @(negedge clk);
    bus1.start = 1'b1; bus1.byte_in = 8'h00;
    @(negedge clk);
    bus1.start = 1'b0;
    d1_len = 0; d1_pat = 16'h0000; d1_mosi = 1'b0; d1_out = 8'h00;
    while (bus1.busy === 1'b1 && d1_len < 40) begin
      if (d1_len < 16) d1_pat = {d1_pat[14:0], bus1.sclk};
      d1_mosi = d1_mosi | bus1.mosi;
      if (bus1.done === 1'b1) d1_out = bus1.slave_output;
      d1_len++;
      @(negedge clk);
    end
    check("div1 busy length", d1_len, 17);
    check("div1 sclk pattern", {16'd0, d1_pat}, 32'h5555);
    check("div1 mosi low", {31'd0, d1_mosi}, 32'd0);
    check("div1 slave_output", {24'd0, d1_out}, 32'hFF);
    check("div1 held output", {24'd0, bus1.slave_output}, 32'hFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d of %0d passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
